// File: rtl/sipo_pkg.sv
// Shared types and line levels for the serial-in/parallel-out framer.
package sipo_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} sipo_state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register; a load that finds the entry full
// and not being drained is dropped and reported as an overrun pulse.
module sipo_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load && (!valid_q || out_ready)) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else begin
      if (valid_q && out_ready) valid_d = 1'b0;
      overrun_d = load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/sipo_framer.sv
// Serial frame receiver: start(0), WIDTH data bits LSB-first, optional even
// parity bit (macro PARITY_CHECK_EN), stop(1); words leave via sipo_out_buf.
module sipo_framer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             par_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sipo_state_t      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH:0]   shift_in;
  logic             load;

`ifdef PARITY_CHECK_EN
  logic par_bit_q, par_bit_d;
  logic par_err_q, par_err_d;
  logic par_ok;
  // Even parity: data bits and parity bit XOR to zero.
  assign par_ok  = ~(^shift_q ^ par_bit_q);
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign shift_in = {ser_in, shift_q};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    load        = 1'b0;
`ifdef PARITY_CHECK_EN
    par_bit_d   = par_bit_q;
    par_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ser_in == START_LVL) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shift_d = shift_in[WIDTH:1];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef PARITY_CHECK_EN
        par_bit_d = ser_in;
`endif
        state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
        // A bad stop bit masks any parity result for the same frame.
        if (ser_in == STOP_LVL) begin
`ifdef PARITY_CHECK_EN
          if (par_ok) load = 1'b1;
          else        par_err_d = 1'b1;
`else
          load = 1'b1;
`endif
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
`ifdef PARITY_CHECK_EN
      par_bit_q   <= par_bit_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  sipo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (shift_q),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_framer.sv
// Self-checking bench for sipo_framer (WIDTH=8); the serial line is fed
// through a local dff, and results are checked from a frame-level model.
module tb_sipo_framer;

  localparam int WIDTH = 8;
`ifdef PARITY_CHECK_EN
  localparam int FL = WIDTH + 3;
`else
  localparam int FL = WIDTH + 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ser_d = 1'b1;
  logic             ser_in = 1'b1;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, frame_err, par_err, overrun, busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Observation log: entry i holds the outputs right after bit i is driven,
  // so a frame whose stop bit sits at index s shows its result at s+1.
  logic             bits_q[$];
  logic             ob_valid[$];
  logic [WIDTH-1:0] ob_data[$];
  logic             ob_ferr[$];
  logic             ob_perr[$];
  logic             ob_ovr[$];

  always #5 clk = ~clk;

  // Upstream registered serial stage.
  always_ff @(posedge clk) ser_in <= ser_d;

  sipo_framer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .par_err   (par_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic drive(input logic b);
    ser_d = b;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_run();
    bits_q.delete();
    ob_valid.delete();
    ob_data.delete();
    ob_ferr.delete();
    ob_perr.delete();
    ob_ovr.delete();
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) bits_q.push_back(1'b1);
  endtask

  task automatic add_frame(input logic [WIDTH-1:0] w, input logic stop_bit,
                           input logic par_flip, output int s);
    bits_q.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) bits_q.push_back(w[i]);
`ifdef PARITY_CHECK_EN
    bits_q.push_back((^w) ^ par_flip);
`else
    if (par_flip) bits_q.push_back(1'b1); // never used without parity
`endif
    bits_q.push_back(stop_bit);
    s = bits_q.size() - 1;
  endtask

  task automatic run_bits();
    for (int i = 0; i < bits_q.size(); i++) begin
      drive(bits_q[i]);
      ob_valid.push_back(out_valid);
      ob_data.push_back(out_data);
      ob_ferr.push_back(frame_err);
      ob_perr.push_back(par_err);
      ob_ovr.push_back(overrun);
      if (out_valid && out_ready)
        $display("[TB] step %0d: word 0x%02h delivered", i, out_data);
    end
  endtask

  function automatic int count_ones(input logic q[$]);
    int c = 0;
    foreach (q[i]) if (q[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0);
    drive(1'b1);
    n_tests++;
    if ({out_valid, frame_err, par_err, overrun, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got v/fe/pe/ov/busy=%b expected 00000",
               {out_valid, frame_err, par_err, overrun, busy});
    end
    n_tests++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got 0x%02h expected 0x00", out_data);
    end
    rst = 1'b0;
    drive(1'b1);
    drive(1'b1);
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    int s;
    out_ready = 1'b1;
    clear_run();
    add_idle(1);
    add_frame(8'hA5, 1'b1, 1'b0, s);
    add_idle(2);
    run_bits();
    n_tests++;
    if (ob_valid[s] !== 1'b0 || ob_valid[s+1] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: valid at stop/after=%b%b expected 01",
               ob_valid[s], ob_valid[s+1]);
    end
    n_tests++;
    if (ob_data[s+1] !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_data: got 0x%02h expected 0xa5", ob_data[s+1]);
    end
    n_tests++;
    if (count_ones(ob_ferr) + count_ones(ob_perr) + count_ones(ob_ovr) != 0) begin
      n_fail++;
      $display("FAIL single_errors: got %0d error pulses expected 0",
               count_ones(ob_ferr) + count_ones(ob_perr) + count_ones(ob_ovr));
    end
    n_tests++;
    if (ob_valid[s+2] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: valid after handshake got %b expected 0", ob_valid[s+2]);
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    out_ready = 1'b1;
    clear_run();
    add_frame(8'h3C, 1'b1, 1'b0, s1);
    add_frame(8'hC3, 1'b1, 1'b0, s2);
    add_idle(2);
    run_bits();
    n_tests++;
    if (ob_valid[s1+1] !== 1'b1 || ob_data[s1+1] !== 8'h3C) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b d=0x%02h expected v=1 d=0x3c",
               ob_valid[s1+1], ob_data[s1+1]);
    end
    n_tests++;
    if (ob_valid[s2+1] !== 1'b1 || ob_data[s2+1] !== 8'hC3) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b d=0x%02h expected v=1 d=0xc3",
               ob_valid[s2+1], ob_data[s2+1]);
    end
    n_tests++;
    if (count_ones(ob_valid) != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d valid cycles expected 2", count_ones(ob_valid));
    end
  endtask

  task automatic test_overrun();
    int s1, s2, last;
    out_ready = 1'b0;
    clear_run();
    add_frame(8'h11, 1'b1, 1'b0, s1);
    add_idle(2);
    add_frame(8'h22, 1'b1, 1'b0, s2);
    add_idle(2);
    run_bits();
    last = ob_valid.size() - 1;
    n_tests++;
    if (ob_valid[s1+1] !== 1'b1 || ob_data[s1+1] !== 8'h11) begin
      n_fail++;
      $display("FAIL ovr_first: got v=%b d=0x%02h expected v=1 d=0x11",
               ob_valid[s1+1], ob_data[s1+1]);
    end
    n_tests++;
    if (ob_ovr[s2+1] !== 1'b1 || count_ones(ob_ovr) != 1) begin
      n_fail++;
      $display("FAIL ovr_pulse: got pulse=%b total=%0d expected 1/1",
               ob_ovr[s2+1], count_ones(ob_ovr));
    end
    n_tests++;
    if (ob_valid[last] !== 1'b1 || ob_data[last] !== 8'h11) begin
      n_fail++;
      $display("FAIL ovr_hold: got v=%b d=0x%02h expected v=1 d=0x11",
               ob_valid[last], ob_data[last]);
    end
    out_ready = 1'b1;
    $display("[TB] consuming word 0x%02h", out_data);
    drive(1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_consume: valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_framing();
    int s1, s2;
    out_ready = 1'b1;
    clear_run();
    add_frame(8'h55, 1'b0, 1'b0, s1);
    add_idle(2);
    add_frame(8'h0F, 1'b1, 1'b0, s2);
    add_idle(2);
    run_bits();
    n_tests++;
    if (ob_ferr[s1+1] !== 1'b1 || count_ones(ob_ferr) != 1) begin
      n_fail++;
      $display("FAIL frame_err_pulse: got pulse=%b total=%0d expected 1/1",
               ob_ferr[s1+1], count_ones(ob_ferr));
    end
    n_tests++;
    if (ob_valid[s1+1] !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_err_nodata: valid got %b expected 0", ob_valid[s1+1]);
    end
    n_tests++;
    if (ob_valid[s2+1] !== 1'b1 || ob_data[s2+1] !== 8'h0F || count_ones(ob_valid) != 1) begin
      n_fail++;
      $display("FAIL frame_err_recover: got v=%b d=0x%02h n=%0d expected v=1 d=0x0f n=1",
               ob_valid[s2+1], ob_data[s2+1], count_ones(ob_valid));
    end
  endtask

  task automatic test_mid_reset();
    int s;
    logic [WIDTH-1:0] w;
    out_ready = 1'b1;
    w = 8'h6B;
    drive(1'b0);
    for (int i = 0; i < 5; i++) drive(w[i]);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy_before: got %b expected 1", busy);
    end
    rst = 1'b1;
    drive(1'b1);
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: got busy=%b valid=%b expected 0/0", busy, out_valid);
    end
    clear_run();
    add_idle(2);
    add_frame(8'h81, 1'b1, 1'b0, s);
    add_idle(2);
    run_bits();
    n_tests++;
    if (ob_valid[s+1] !== 1'b1 || ob_data[s+1] !== 8'h81 || count_ones(ob_valid) != 1) begin
      n_fail++;
      $display("FAIL midrst_next: got v=%b d=0x%02h n=%0d expected v=1 d=0x81 n=1",
               ob_valid[s+1], ob_data[s+1], count_ones(ob_valid));
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    int s1, s2;
    out_ready = 1'b1;
    clear_run();
    add_frame(8'hA5, 1'b1, 1'b0, s1);
    add_idle(1);
    add_frame(8'hA5, 1'b1, 1'b1, s2);
    add_idle(2);
    run_bits();
    n_tests++;
    if (ob_valid[s1+1] !== 1'b1 || ob_data[s1+1] !== 8'hA5) begin
      n_fail++;
      $display("FAIL parity_good: got v=%b d=0x%02h expected v=1 d=0xa5",
               ob_valid[s1+1], ob_data[s1+1]);
    end
    n_tests++;
    if (ob_perr[s2+1] !== 1'b1 || count_ones(ob_perr) != 1 || count_ones(ob_valid) != 1) begin
      n_fail++;
      $display("FAIL parity_bad: got pe=%b npe=%0d nvalid=%0d expected 1/1/1",
               ob_perr[s2+1], count_ones(ob_perr), count_ones(ob_valid));
    end
  endtask
`endif

  task automatic test_random();
    int s_list[$];
    logic [WIDTH-1:0] w_list[$];
    logic bad_list[$];
    int n_good = 0, n_bad = 0, s;
    logic [WIDTH-1:0] w;
    logic bad;
    out_ready = 1'b1;
    clear_run();
    for (int k = 0; k < 40; k++) begin
      w   = WIDTH'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      add_frame(w, ~bad, 1'b0, s);
      s_list.push_back(s);
      w_list.push_back(w);
      bad_list.push_back(bad);
      if (bad) n_bad++; else n_good++;
      add_idle($urandom_range(0, 2));
    end
    add_idle(2);
    run_bits();
    foreach (s_list[k]) begin
      s = s_list[k];
      n_tests++;
      if (bad_list[k]) begin
        if (ob_ferr[s+1] !== 1'b1 || ob_valid[s+1] !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_bad[%0d]: got fe=%b v=%b expected fe=1 v=0",
                   k, ob_ferr[s+1], ob_valid[s+1]);
        end
      end else if (ob_valid[s+1] !== 1'b1 || ob_data[s+1] !== w_list[k]) begin
        n_fail++;
        $display("FAIL rand_good[%0d]: got v=%b d=0x%02h expected v=1 d=0x%02h",
                 k, ob_valid[s+1], ob_data[s+1], w_list[k]);
      end
    end
    n_tests++;
    if (count_ones(ob_valid) != n_good || count_ones(ob_ferr) != n_bad ||
        count_ones(ob_ovr) != 0 || count_ones(ob_perr) != 0) begin
      n_fail++;
      $display("FAIL rand_totals: got v=%0d fe=%0d ov=%0d pe=%0d expected v=%0d fe=%0d ov=0 pe=0",
               count_ones(ob_valid), count_ones(ob_ferr), count_ones(ob_ovr),
               count_ones(ob_perr), n_good, n_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_mid_reset();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
